// File: rtl/i2s_capture_ctrl.sv
// Session sequencer for the I2S mic capture path: warm-up discard, counted capture into the sample FIFO, status.
// Optional watchdog enabled by defining I2S_CAPTURE_TIMEOUT_EN.
module i2s_capture_ctrl #(
  parameter int SAMPLE_W       = 16,
  parameter int COUNT_W        = 24,
  parameter int WARMUP_SAMPLES = 4096,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [COUNT_W-1:0]  sample_count_i,
  input  logic                pcm_valid_i,
  input  logic [SAMPLE_W-1:0] pcm_data_i,
  input  logic                fifo_full_i,
  output logic                mic_en_o,
  output logic                fifo_wr_o,
  output logic [SAMPLE_W-1:0] fifo_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                overflow_o,
  output logic                timeout_o,
  output logic [COUNT_W-1:0]  captured_cnt_o,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  localparam int WARM_W = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES + 1) : 1;
  localparam logic [WARM_W-1:0] WARM_LAST =
    WARM_W'((WARMUP_SAMPLES == 0) ? 0 : WARMUP_SAMPLES - 1);
  localparam state_e START_STATE = (WARMUP_SAMPLES == 0) ? S_CAPTURE : S_WARMUP;

  state_e              state_q, state_d;
  logic [COUNT_W-1:0]  target_q, target_d;
  logic [COUNT_W-1:0]  cnt_q, cnt_d;
  logic [COUNT_W-1:0]  cnt_inc;
  logic [WARM_W-1:0]   warm_q, warm_d;
  logic                overflow_q, overflow_d;
  logic                fifo_wr_q, fifo_wr_d;
  logic [SAMPLE_W-1:0] fifo_data_q, fifo_data_d;

`ifdef I2S_CAPTURE_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    warm_d      = warm_q;
    overflow_d  = overflow_q;
    fifo_wr_d   = 1'b0;
    fifo_data_d = fifo_data_q;
`ifdef I2S_CAPTURE_TIMEOUT_EN
    wd_d        = wd_q;
    timeout_d   = timeout_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          target_d   = sample_count_i;
          cnt_d      = '0;
          warm_d     = '0;
          overflow_d = 1'b0;
          state_d    = START_STATE;
`ifdef I2S_CAPTURE_TIMEOUT_EN
          wd_d       = '0;
          timeout_d  = 1'b0;
`endif
        end
      end
      S_WARMUP: begin
        if (stop_i) begin
          state_d = S_DONE;
        end else if (pcm_valid_i) begin
          if (warm_q == WARM_LAST) state_d = S_CAPTURE;
          else                     warm_d  = warm_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        // A stop coincident with a sample aborts before that sample is written.
        if (stop_i) begin
          state_d = S_DONE;
        end else if (pcm_valid_i) begin
          if (fifo_full_i) begin
            overflow_d = 1'b1;
          end else begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = pcm_data_i;
            cnt_d       = cnt_inc;
            if ((target_q != '0) && (cnt_inc == target_q)) state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef I2S_CAPTURE_TIMEOUT_EN
    if ((state_q == S_WARMUP || state_q == S_CAPTURE) && !stop_i) begin
      if (pcm_valid_i) begin
        wd_d = '0;
      end else if (wd_q == WD_LAST) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      target_q    <= '0;
      cnt_q       <= '0;
      warm_q      <= '0;
      overflow_q  <= 1'b0;
      fifo_wr_q   <= 1'b0;
      fifo_data_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      warm_q      <= warm_d;
      overflow_q  <= overflow_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

`ifdef I2S_CAPTURE_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  // The mic clock runs exactly while a session is active.
  assign busy_o         = (state_q == S_WARMUP) || (state_q == S_CAPTURE);
  assign mic_en_o       = busy_o;
  assign done_o         = (state_q == S_DONE);
  assign overflow_o     = overflow_q;
  assign fifo_wr_o      = fifo_wr_q;
  assign fifo_data_o    = fifo_data_q;
  assign captured_cnt_o = cnt_q;
  assign state_o        = state_q;

endmodule
